// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared constants and helpers for the N-digit 7-segment display driver.
//   - SEG_0..SEG_F : active-low glyphs, bit order {g,f,e,d,c,b,a}
//   - SEG_BLANK    : all segments off
//   - SEG_ALL_OFF  : all anodes off (active-low), sliced to DIGITS by users
//   - hex_to_seg() : nibble to active-low glyph
// ---------------------------------------------------------------------------
package seg7_pkg;

    localparam int unsigned SEG_W      = 7;
    localparam int unsigned NIB_W      = 4;
    localparam int unsigned MAX_DIGITS = 8;

    localparam logic [SEG_W-1:0] SEG_0 = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1 = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2 = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3 = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4 = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5 = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6 = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7 = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8 = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9 = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG_A = 7'b0001000;
    localparam logic [SEG_W-1:0] SEG_B = 7'b0000011;
    localparam logic [SEG_W-1:0] SEG_C = 7'b1000110;
    localparam logic [SEG_W-1:0] SEG_D = 7'b0100001;
    localparam logic [SEG_W-1:0] SEG_E = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_F = 7'b0001110;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    // Anodes are active-low, so "all off" is all ones.
    localparam logic [MAX_DIGITS-1:0] SEG_ALL_OFF = '1;

    // Nibble to active-low glyph; 10..15 render as A b C d E F.
    function automatic logic [SEG_W-1:0] hex_to_seg(input logic [NIB_W-1:0] nibble);
        logic [SEG_W-1:0] glyph;
        glyph = SEG_BLANK;
        case (nibble)
            4'h0: glyph = SEG_0;
            4'h1: glyph = SEG_1;
            4'h2: glyph = SEG_2;
            4'h3: glyph = SEG_3;
            4'h4: glyph = SEG_4;
            4'h5: glyph = SEG_5;
            4'h6: glyph = SEG_6;
            4'h7: glyph = SEG_7;
            4'h8: glyph = SEG_8;
            4'h9: glyph = SEG_9;
            4'hA: glyph = SEG_A;
            4'hB: glyph = SEG_B;
            4'hC: glyph = SEG_C;
            4'hD: glyph = SEG_D;
            4'hE: glyph = SEG_E;
            4'hF: glyph = SEG_F;
            default: glyph = SEG_BLANK;
        endcase
        return glyph;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// ---------------------------------------------------------------------------
// seg7_decoder
// Combinational nibble-to-glyph decoder with a blank override.
//   nibble_i : hex/BCD nibble to render
//   blank_i  : force all segments off (leading-zero blanking)
//   seg_c_o  : active-low segments {g,f,e,d,c,b,a}, combinational
// ---------------------------------------------------------------------------
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [NIB_W-1:0] nibble_i,
    input  logic             blank_i,
    output logic [SEG_W-1:0] seg_c_o
);

    always_comb begin
        seg_c_o = hex_to_seg(nibble_i);
        if (blank_i) begin
            seg_c_o = SEG_BLANK;
        end
    end

endmodule

// File: rtl/seg7_mux_ndigit.sv
// ---------------------------------------------------------------------------
// seg7_mux_ndigit
// Time-multiplexed N-digit common-anode 7-segment driver. Inputs are
// snapshotted once per frame so a frame never mixes old and new values;
// each digit slot opens with a dark interval to suppress ghosting.
//
// Parameters: DIGITS (1..8), REFRESH_DIV (cycles per slot, >= BLANK_CYC+2),
//             BLANK_CYC (dark cycles at the start of each slot)
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   en          : display enable (0 holds scan at digit 0 and darkens display)
//   blank_lz    : leading-zero blanking request
//   digits      : DIGITS packed nibbles, digit 0 rightmost
//   dp_in       : per-digit decimal point request, active-high
//   seg, dp, an : registered active-low display pins
//   frame_tick  : one-cycle pulse when a new frame snapshot is taken
//
// Build option: define SEG7_LZ_BLANK_EN to include leading-zero blanking;
// without it blank_lz is ignored and no blanking logic exists.
// ---------------------------------------------------------------------------
module seg7_mux_ndigit
    import seg7_pkg::*;
#(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned BLANK_CYC   = 500
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    blank_lz,
    input  logic [NIB_W*DIGITS-1:0] digits,
    input  logic [DIGITS-1:0]       dp_in,
    output logic [SEG_W-1:0]        seg,
    output logic                    dp,
    output logic [DIGITS-1:0]       an,
    output logic                    frame_tick
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned DIG_W = NIB_W * DIGITS;

    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] DARK_END  = CNT_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0] AN_OFF   = SEG_ALL_OFF[DIGITS-1:0];

    logic [CNT_W-1:0]  slot_cnt_q, slot_cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DIG_W-1:0]  snap_dig_q, snap_dig_d;
    logic [DIGITS-1:0] snap_dp_q, snap_dp_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [SEG_W-1:0]  seg_q, seg_d;
    logic              dp_q, dp_d;
    logic              frame_tick_q, frame_tick_d;

    logic              slot_end_c;
    logic              frame_end_c;
    logic              lit_c;
    logic [NIB_W-1:0]  cur_nib_c;
    logic              cur_dp_c;
    logic              lz_blank_c;
    logic [SEG_W-1:0]  dec_seg_c;

    assign slot_end_c  = (slot_cnt_q == SLOT_LAST);
    assign frame_end_c = slot_end_c && (idx_q == IDX_LAST);
    assign lit_c       = en && (slot_cnt_q >= DARK_END);

    // Slot/index counters and frame snapshot.
    always_comb begin
        slot_cnt_d   = slot_cnt_q;
        idx_d        = idx_q;
        snap_dig_d   = snap_dig_q;
        snap_dp_d    = snap_dp_q;
        frame_tick_d = 1'b0;

        if (!en) begin
            // Idle: park at digit 0 and keep tracking the inputs so the
            // first enabled frame shows current values.
            slot_cnt_d = '0;
            idx_d      = '0;
            snap_dig_d = digits;
            snap_dp_d  = dp_in;
        end else begin
            if (slot_end_c) begin
                slot_cnt_d = '0;
                idx_d      = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            end else begin
                slot_cnt_d = slot_cnt_q + CNT_W'(1);
            end
            if (frame_end_c) begin
                snap_dig_d   = digits;
                snap_dp_d    = dp_in;
                frame_tick_d = 1'b1;
            end
        end
    end

    // Select the snapshot nibble and decimal point for the current digit.
    always_comb begin
        cur_nib_c = '0;
        cur_dp_c  = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib_c = snap_dig_q[NIB_W*i +: NIB_W];
                cur_dp_c  = snap_dp_q[i];
            end
        end
    end

`ifdef SEG7_LZ_BLANK_EN
    logic [DIGITS-1:0] lz_mask_c;

    // Digit i>0 is a leading zero when it and every digit above it are zero.
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        lz_mask_c  = '0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            zero_above   = zero_above && (snap_dig_q[NIB_W*i +: NIB_W] == 4'h0);
            lz_mask_c[i] = (i != 0) && zero_above;
        end
    end

    always_comb begin
        lz_blank_c = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx_q == IDX_W'(i)) begin
                lz_blank_c = blank_lz && lz_mask_c[i];
            end
        end
    end
`else
    logic unused_blank_lz;
    assign unused_blank_lz = blank_lz;
    assign lz_blank_c      = 1'b0;
`endif

    seg7_decoder u_decoder (
        .nibble_i (cur_nib_c),
        .blank_i  (lz_blank_c),
        .seg_c_o  (dec_seg_c)
    );

    // Display pins: dark unless enabled and past the slot's dark interval.
    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (lit_c) begin
            for (int i = 0; i < int'(DIGITS); i++) begin
                if (idx_q == IDX_W'(i)) begin
                    an_d[i] = 1'b0;
                end
            end
            seg_d = dec_seg_c;
            dp_d  = ~cur_dp_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_cnt_q   <= '0;
            idx_q        <= '0;
            snap_dig_q   <= '0;
            snap_dp_q    <= '0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            slot_cnt_q   <= slot_cnt_d;
            idx_q        <= idx_d;
            snap_dig_q   <= snap_dig_d;
            snap_dp_q    <= snap_dp_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_mux_ndigit.sv
// ---------------------------------------------------------------------------
// tb_seg7_mux_ndigit
// Scoreboard bench for seg7_mux_ndigit (DIGITS=4, REFRESH_DIV=8, BLANK_CYC=2).
// A reference model derives each cycle's expected pins from elapsed scan
// time and a per-frame copy of the inputs, and queues them; a monitor pops
// and compares against the DUT every cycle.
// ---------------------------------------------------------------------------
module tb_seg7_mux_ndigit;

    localparam int D  = 4;
    localparam int RD = 8;
    localparam int BC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        blank_lz;
    logic [15:0] digits;
    logic [3:0]  dp_in;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_tick;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       ft;
    } exp_t;

    exp_t exp_q[$];

    // Active-low glyphs for 0-9, A b C d E F.
    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg7_mux_ndigit #(
        .DIGITS      (D),
        .REFRESH_DIV (RD),
        .BLANK_CYC   (BC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .blank_lz   (blank_lz),
        .digits     (digits),
        .dp_in      (dp_in),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int         t_scan;
    logic [3:0] m_nib [D];
    logic [3:0] m_dp;

    function automatic logic [6:0] shown(input int i);
        logic blanked;
        blanked = 1'b0;
`ifdef SEG7_LZ_BLANK_EN
        if (blank_lz && i > 0) begin
            blanked = 1'b1;
            for (int j = i; j < D; j++) begin
                if (m_nib[j] != 4'h0) blanked = 1'b0;
            end
        end
`endif
        return blanked ? 7'h7F : glyph[m_nib[i]];
    endfunction

    always @(posedge clk) begin : model
        exp_t e;
        int   slot;
        int   idx;
        e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, ft: 1'b0};
        if (rst) begin
            t_scan = 0;
            m_dp   = '0;
            for (int i = 0; i < D; i++) m_nib[i] = 4'h0;
        end else if (!en) begin
            t_scan = 0;
            for (int i = 0; i < D; i++) m_nib[i] = digits[4*i +: 4];
            m_dp = dp_in;
        end else begin
            slot = t_scan % RD;
            idx  = (t_scan / RD) % D;
            if (slot >= BC) begin
                e.an      = 4'hF;
                e.an[idx] = 1'b0;
                e.seg     = shown(idx);
                e.dp      = ~m_dp[idx];
            end
            if (slot == RD - 1 && idx == D - 1) begin
                e.ft = 1'b1;
                for (int i = 0; i < D; i++) m_nib[i] = digits[4*i +: 4];
                m_dp = dp_in;
            end
            t_scan++;
        end
        exp_q.push_back(e);
    end

    // ---------------- monitor ----------------
    always @(posedge clk) begin : monitor
        exp_t e;
        #2;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check("an", 32'(an), 32'(e.an));
            check("dp", 32'(dp), 32'(e.dp));
            check("frame_tick", 32'(frame_tick), 32'(e.ft));
            if (e.an != 4'hF) check("seg", 32'(seg), 32'(e.seg));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [15:0] v;
        int          lz;
        int          found;

        rst = 1'b1; en = 1'b1; blank_lz = 1'b0; digits = 16'h1234; dp_in = 4'b0000;
        cycles(3);
        rst = 1'b0;
        cycles(70);

        // Change inputs while digit 2 is lit; the frame must not tear.
        found = 0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk);
            if (an === 4'b1011) found = 1;
        end
        check("wait_digit2", 32'(found), 32'd1);
        digits = 16'hABCD;
        cycles(70);

        dp_in = 4'b0100;
        cycles(40);

        // Asynchronous reset mid-slot.
        cycles(5);
        #1 rst = 1'b1;
        #1;
        check("rst_an_async", 32'(an), 32'hF);
        check("rst_seg_async", 32'(seg), 32'h7F);
        check("rst_dp_async", 32'(dp), 32'd1);
        cycles(2);
        rst = 1'b0;
        cycles(40);

        // Enable dropped for 20 cycles.
        en = 1'b0;
        cycles(20);
        en = 1'b1;
        cycles(40);

        // Leading-zero patterns.
        blank_lz = 1'b1; dp_in = 4'b0000;
        digits = 16'h0050; cycles(70);
        digits = 16'h0000; cycles(70);
        digits = 16'h0900; cycles(70);
        blank_lz = 1'b0;
        digits = 16'h0050; cycles(40);

        // Randomized traffic.
        for (int it = 0; it < 40; it++) begin
            v  = 16'($urandom);
            lz = int'($urandom_range(0, 4));
            for (int k = 0; k < lz; k++) v[4*(3-k) +: 4] = 4'h0;
            digits   = v;
            dp_in    = 4'($urandom);
            blank_lz = 1'($urandom);
            cycles(int'($urandom_range(1, 50)));
            case ($urandom_range(0, 7))
                0: begin
                    en = 1'b0;
                    cycles(int'($urandom_range(1, 10)));
                    en = 1'b1;
                end
                1: begin
                    #2 rst = 1'b1;
                    cycles(int'($urandom_range(1, 2)));
                    rst = 1'b0;
                end
                default: ;
            endcase
        end

        cycles(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_mux_ndigit.md
# seg7_mux_ndigit

Parametrised N-digit time-multiplexed 7-segment display driver, the successor to the fixed 4-digit BCD driver. It takes DIGITS packed 4-bit hex/BCD nibbles plus per-digit decimal points, snapshots them once per refresh frame, and scans the common-anode display one digit per slot. Each slot has a programmable dark interval to suppress ghosting, and leading-zero blanking is optional. It sits between the robot status/counter logic and the board display pins.

## Interface
- DIGITS, 4, number of digits scanned; legal range 1..8
- REFRESH_DIV, 50000, clock cycles per digit slot; must be ≥ BLANK_CYC+2
- BLANK_CYC, 500, cycles at the start of each slot with all anodes off

- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- en  in  1  display enable
- blank_lz  in  1  leading-zero blanking request (only honoured when compiled in)
- digits  in  4*DIGITS  nibble i = digits[4i+3:4i]; digit 0 is rightmost
- dp_in  in  DIGITS  decimal point request per digit, active-high
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point segment, active-low
- an  out  DIGITS  anode selects, active-low, at most one low at a time
- frame_tick  out  1  one-cycle pulse when a new frame snapshot is taken

## Operation
- Slot counter `slot_cnt` runs 0..REFRESH_DIV-1. When it reaches REFRESH_DIV-1, the digit index `idx` advances, wrapping from DIGITS-1 to 0.
- Snapshot: on the edge where `idx` wraps to 0, `digits` and `dp_in` are copied into internal registers, and `frame_tick` is asserted for that one cycle. Input changes mid-frame are not displayed until the next frame, so there is no tearing.
- Dark interval: while `slot_cnt` < BLANK_CYC, `an` is all 1s. Otherwise `an[idx]`=0.
- Glyphs: 0-9 use standard patterns (0 → 7'b1000000, 8 → 7'b0000000). 10-15 display A, b, C, d, E, F (A → 7'b0001000, F → 7'b0001110).
- Leading-zero blanking (when active): digit i>0 shows seg=7'h7F if snapshot nibbles i..DIGITS-1 are all zero. Digit 0 is never blanked. `dp` is unaffected by blanking.
- `en`=0: `slot_cnt` and `idx` are held at 0, `an` is all 1s, `seg`=7'h7F, `dp`=1, and the snapshot is loaded every cycle. On the first cycle with `en`=1, scanning starts at digit 0 with a full dark interval.
- DIGITS=1: `idx` stays 0, and a snapshot plus `frame_tick` occur at every slot end.

## Timing
- Reset values: an all 1s, seg=7'h7F, dp=1, frame_tick=0, slot_cnt=0, idx=0, snapshot all 0.
- All outputs are registered. `an`/`seg`/`dp` reflect the `slot_cnt`/`idx` state of the previous cycle (1-cycle latency).
- Input to display latency: worst case one frame (DIGITS×REFRESH_DIV) plus 1 cycle.
- Frame period: DIGITS×REFRESH_DIV cycles. `frame_tick` spacing is exactly this value while `en`=1.
- Reset asserted mid-slot: outputs go to reset values immediately (asynchronous). Scanning resumes from digit 0, slot_cnt 0, after deassertion.
- `en` falling mid-slot: `an` is all 1s on the next edge.

## Configuration
- SEG7_LZ_BLANK_EN defined: leading-zero blanking logic is present and gated by `blank_lz`.
- SEG7_LZ_BLANK_EN undefined: `blank_lz` is ignored, every digit always shows its glyph, and no blanking logic is synthesised.

## Structure
- Package `seg7_pkg`:
  - active-low glyph constants SEG_0..SEG_F and SEG_BLANK (7'h7F)
  - SEG_ALL_OFF anode helper
  - function `hex_to_seg(nibble)`
- Sub-module `seg7_decoder`: combinational nibble + blank → seg, instantiated once on the muxed nibble.
- Top module contains the slot counter, index counter, snapshot registers, blanking mask and output registers.

## Test plan
Bench parameters: DIGITS=4, REFRESH_DIV=8, BLANK_CYC=2.

- Reset check: rst pulse asserted mid-scan → an=4'b1111, seg=7'h7F, dp=1 within the same cycle. After release, first an=4'b1110 appears 3 cycles later.
- Scan order: digits=16'h1234, dp_in=0 → an cycles 1110 (seg=4 → 7'b0011001), 1101 (3), 1011 (2), 0111 (1). Each anode is low for 6 cycles, followed by 2 dark cycles. frame_tick period is 32 cycles.
- Snapshot: change digits from 16'h1234 to 16'hABCD while digit 2 is displayed → digit 3 still shows 1; digit 0 shows D (7'b0100001) only after the next frame_tick.
- Leading-zero blanking (SEG7_LZ_BLANK_EN defined, blank_lz=1): digits=16'h0050 → digits 3 and 2 show 7'h7F, digit 1 shows 5, digit 0 shows 0. With digits=16'h0000, only digit 0 shows 0. With the macro undefined, digit 3 shows 7'b1000000.
- Decimal point: dp_in=4'b0100 → dp=0 only while an=4'b1011.
- Enable: `en` dropped for 20 cycles → an=4'b1111 throughout. After re-enable, the first lit anode is 1110, at cycle 3.
